usb_rx_controller: RTL and testbench

Receive-side sequencer for the Serial Interface Engine. It runs one bit per clk alongside the NRZI decoder and takes the decoder's decoded bit plus the raw DP/DM line state. It performs SYNC detection, bit unstuffing, LSB-first byte assembly and EOP detection. It hands bytes and packet status to the packet-level logic.

---
 rtl/usb_sie_pkg.sv | 27 ++
 rtl/usb_bit_unstuffer.sv | 38 +++
 rtl/usb_rx_controller.sv | 212 +++++++++++++++++++++
 tb/tb_usb_rx_controller.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_sie_pkg.sv
// Shared definitions for the USB Serial Interface Engine receive path:
// FSM states, DP/DM line-state codes and receive error codes.
package usb_sie_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_EOP  = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  // Line states are {DP, DM}
  localparam logic [1:0] LINE_SE0 = 2'b00;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_SE1 = 2'b11;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_STUFF = 2'b01;
  localparam logic [1:0] ERR_FRAME = 2'b10;
  localparam logic [1:0] ERR_OVF   = 2'b11;

  function automatic logic [2:0] sat_inc3(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

endpackage

// File: rtl/usb_bit_unstuffer.sv
// Tracks the run of decoded 1s and flags each bit as a stuffed 0 to drop
// or as a stuffing violation once the run reaches STUFF_LEN.
module usb_bit_unstuffer #(
  parameter int STUFF_LEN = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic bit_en,
  input  logic bit_in,
  output logic discard,
  output logic stuff_err
);

  localparam int RUN_W = $clog2(STUFF_LEN + 1);

  logic [RUN_W-1:0] ones_run;
  logic             at_limit;

  assign at_limit  = (ones_run == RUN_W'(STUFF_LEN));
  assign discard   = at_limit && !bit_in;
  assign stuff_err = at_limit && bit_in;

  // The SYNC field's final 1 starts the run, so load seeds it with one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ones_run <= '0;
    end else if (load) begin
      ones_run <= RUN_W'(1);
    end else if (bit_en) begin
      if (!bit_in)
        ones_run <= '0;
      else if (!at_limit)
        ones_run <= ones_run + RUN_W'(1);
    end
  end

endmodule

// File: rtl/usb_rx_controller.sv
// Receive sequencer: SYNC detection, bit unstuffing, LSB-first byte assembly
// and EOP detection, one decoded bit per clk.
module usb_rx_controller
  import usb_sie_pkg::*;
#(
  parameter int SYNC_MIN_ZEROS = 6,
  parameter int STUFF_LEN      = 6,
  parameter int MAX_BYTES      = 1027,
  parameter int IDLE_J_BITS    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        DPin,
  input  logic        DMin,
  input  logic        dec_bit,
  output logic        rx_active,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  output logic        rx_done,
  output logic        rx_error,
  output logic [1:0]  rx_err_code,
  output logic [10:0] rx_byte_cnt
);

  localparam int JW = $clog2(IDLE_J_BITS + 1);

  state_t        state, state_n;
  logic [2:0]    zero_cnt, zero_n;
  logic [2:0]    bit_cnt, bit_n;
  logic [1:0]    se0_cnt, se0_n;
  logic [JW-1:0] j_cnt, j_n;
  logic [7:0]    shift, shift_n, data_n;
  logic          valid_n, done_n, error_n;
  logic [1:0]    code_n;
  logic [10:0]   cnt_n;
  logic          sync_load, bit_en, discard, stuff_err;
  logic [1:0]    line;

  assign line      = {DPin, DMin};
  assign rx_active = (state == ST_DATA) || (state == ST_EOP);

  usb_bit_unstuffer #(
    .STUFF_LEN (STUFF_LEN)
  ) u_unstuff (
    .clk       (clk),
    .rst       (rst),
    .load      (sync_load),
    .bit_en    (bit_en),
    .bit_in    (dec_bit),
    .discard   (discard),
    .stuff_err (stuff_err)
  );

  always_comb begin
    state_n   = state;
    zero_n    = zero_cnt;
    bit_n     = bit_cnt;
    se0_n     = se0_cnt;
    j_n       = j_cnt;
    shift_n   = shift;
    data_n    = rx_data;
    valid_n   = 1'b0;
    done_n    = 1'b0;
    error_n   = 1'b0;
    code_n    = rx_err_code;
    cnt_n     = rx_byte_cnt;
    sync_load = 1'b0;
    bit_en    = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (line == LINE_SE0 || line == LINE_SE1) begin
          zero_n = '0;
        end else if (!dec_bit) begin
          zero_n = sat_inc3(zero_cnt);
        end else if (zero_cnt >= 3'(SYNC_MIN_ZEROS)) begin
          state_n   = ST_DATA;
          sync_load = 1'b1;
          zero_n    = '0;
          bit_n     = '0;
          cnt_n     = '0;
          code_n    = ERR_NONE;
        end else begin
          zero_n = '0;
        end
      end

      ST_DATA: begin
        if (line == LINE_SE0) begin
          state_n = ST_EOP;
          se0_n   = 2'd1;
        end else if (line == LINE_SE1) begin
          state_n = ST_ERR;
          error_n = 1'b1;
          code_n  = ERR_OVF;
          j_n     = '0;
        end else begin
          bit_en = 1'b1;
          if (stuff_err) begin
            state_n = ST_ERR;
            error_n = 1'b1;
            code_n  = ERR_STUFF;
            j_n     = '0;
          end else if (!discard) begin
            shift_n = {dec_bit, shift[7:1]};
            bit_n   = bit_cnt + 3'd1;
            // Overflow wins over the byte completing on the same bit.
            if (bit_cnt == 3'd7) begin
              if (rx_byte_cnt == 11'(MAX_BYTES)) begin
                state_n = ST_ERR;
                error_n = 1'b1;
                code_n  = ERR_OVF;
                j_n     = '0;
              end else begin
                data_n  = shift_n;
                valid_n = 1'b1;
                cnt_n   = rx_byte_cnt + 11'd1;
              end
            end
          end
        end
      end

      ST_EOP: begin
        unique case (line)
          LINE_SE0: begin
            if (se0_cnt == 2'd3) begin
              state_n = ST_ERR;
              error_n = 1'b1;
              code_n  = ERR_FRAME;
              j_n     = '0;
            end else begin
              se0_n = se0_cnt + 2'd1;
            end
          end
          LINE_J: begin
            if (se0_cnt >= 2'd2) begin
              state_n = ST_IDLE;
              done_n  = 1'b1;
              zero_n  = '0;
              if (bit_cnt != 3'd0) begin
                error_n = 1'b1;
                code_n  = ERR_FRAME;
              end
            end else begin
              state_n = ST_ERR;
              error_n = 1'b1;
              code_n  = ERR_FRAME;
              j_n     = '0;
            end
          end
          default: begin
            state_n = ST_ERR;
            error_n = 1'b1;
            code_n  = ERR_FRAME;
            j_n     = '0;
          end
        endcase
      end

      ST_ERR: begin
        if (line == LINE_J) begin
          if (j_cnt == JW'(IDLE_J_BITS - 1)) begin
            state_n = ST_IDLE;
            zero_n  = '0;
            j_n     = '0;
          end else begin
            j_n = j_cnt + JW'(1);
          end
        end else begin
          j_n = '0;
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      zero_cnt    <= '0;
      bit_cnt     <= '0;
      se0_cnt     <= '0;
      j_cnt       <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_done     <= 1'b0;
      rx_error    <= 1'b0;
      rx_err_code <= ERR_NONE;
      rx_byte_cnt <= '0;
    end else begin
      state       <= state_n;
      zero_cnt    <= zero_n;
      bit_cnt     <= bit_n;
      se0_cnt     <= se0_n;
      j_cnt       <= j_n;
      rx_data     <= data_n;
      rx_valid    <= valid_n;
      rx_done     <= done_n;
      rx_error    <= error_n;
      rx_err_code <= code_n;
      rx_byte_cnt <= cnt_n;
    end
  end

  // Partial shift contents are never visible, so they need no reset.
  always_ff @(posedge clk) begin
    shift <= shift_n;
  end

endmodule

// File: tb/tb_usb_rx_controller.sv
// Self-checking bench for usb_rx_controller: packet vectors from a table,
// hand-written corner sequences and randomized packets against a line encoder.
module tb_usb_rx_controller;

  localparam int MAXB = 1027;
  localparam logic [1:0] LJ = 2'b10, LK = 2'b01, LSE0 = 2'b00, LSE1 = 2'b11;

  logic        clk = 1'b0;
  logic        rst, DPin, DMin, dec_bit;
  logic        rx_active, rx_valid, rx_done, rx_error;
  logic [7:0]  rx_data;
  logic [1:0]  rx_err_code;
  logic [10:0] rx_byte_cnt;

  always #5 clk = ~clk;

  usb_rx_controller #(
    .SYNC_MIN_ZEROS (6),
    .STUFF_LEN      (6),
    .MAX_BYTES      (MAXB),
    .IDLE_J_BITS    (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .DPin        (DPin),
    .DMin        (DMin),
    .dec_bit     (dec_bit),
    .rx_active   (rx_active),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_done     (rx_done),
    .rx_error    (rx_error),
    .rx_err_code (rx_err_code),
    .rx_byte_cnt (rx_byte_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Monitor: collect events at the falling edge, away from the active edge.
  logic [7:0] got_q[$];
  int n_done = 0, n_err = 0, n_both = 0, n_act = 0;
  always @(negedge clk) begin
    if (rx_valid) got_q.push_back(rx_data);
    if (rx_done) n_done++;
    if (rx_error) n_err++;
    if (rx_done && rx_error) n_both++;
    if (rx_active) n_act++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  // Line encoder: one symbol per clk; stuffing counts the SYNC's final 1.
  int run;
  task automatic sym(input logic [1:0] l, input logic b);
    {DPin, DMin} = l;
    dec_bit = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) sym(LJ, 1'b1);
  endtask

  task automatic sync(input int nz);
    for (int i = 0; i < nz; i++) sym(LK, 1'b0);
    sym(LK, 1'b1);
    run = 1;
  endtask

  task automatic send_bit(input logic b);
    sym(b ? LJ : LK, b);
    if (b) run++; else run = 0;
    if (run == 6) begin
      sym(LK, 1'b0);
      run = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  task automatic eop();
    sym(LSE0, 1'b0);
    sym(LSE0, 1'b0);
    sym(LJ, 1'b1);
  endtask

  task automatic recover();
    sym(LK, 1'b0);
    idle(8);
  endtask

  logic [7:0] pkt_q[$];

  task automatic run_packet(input int lead, input int nz, input int extra, input logic [7:0] xbits,
                            input logic exp_err, input logic [1:0] exp_code, input int exp_cnt,
                            input string tag);
    int bv, bd, be, bb, bad;
    bv = got_q.size(); bd = n_done; be = n_err; bb = n_both;
    idle(lead);
    sync(nz);
    foreach (pkt_q[i]) send_byte(pkt_q[i]);
    for (int i = 0; i < extra; i++) send_bit(xbits[i]);
    eop();
    idle(2);
    chk({tag, " nbytes"}, 32'(got_q.size() - bv), 32'(pkt_q.size()));
    bad = 0;
    for (int i = 0; i < pkt_q.size(); i++)
      if (bv + i >= got_q.size() || got_q[bv + i] !== pkt_q[i]) bad++;
    chk({tag, " bytes"}, 32'(bad), 32'd0);
    chk({tag, " done"}, 32'(n_done - bd), 32'd1);
    chk({tag, " error"}, 32'(n_err - be), 32'(exp_err));
    chk({tag, " done+error"}, 32'(n_both - bb), 32'(exp_err));
    chk({tag, " code"}, 32'(rx_err_code), 32'(exp_code));
    chk({tag, " byte_cnt"}, 32'(rx_byte_cnt), 32'(exp_cnt));
    chk({tag, " active"}, 32'(rx_active), 32'd0);
  endtask

  typedef struct {
    int          nz;
    int          nbytes;
    logic [31:0] bytes;
    int          extra;
    logic [7:0]  xbits;
    logic        exp_err;
    logic [1:0]  exp_code;
    int          exp_cnt;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int bd, be, ba, bv, n, extra, nz;
    logic [7:0] xb;

    tbl[0] = '{7, 2, 32'h0000_3CA5, 0, 8'h00, 1'b0, 2'b00, 2};
    tbl[1] = '{7, 1, 32'h0000_00FF, 0, 8'h00, 1'b0, 2'b00, 1};
    tbl[2] = '{7, 1, 32'h0000_00A5, 3, 8'h05, 1'b1, 2'b10, 1};
    tbl[3] = '{6, 4, 32'h7E81_FF00, 0, 8'h00, 1'b0, 2'b00, 4};
    tbl[4] = '{7, 0, 32'h0000_0000, 0, 8'h00, 1'b0, 2'b00, 0};
    tbl[5] = '{7, 4, 32'hFFFF_FFFF, 0, 8'h00, 1'b0, 2'b00, 4};
    tbl[6] = '{6, 1, 32'h0000_0012, 7, 8'h7F, 1'b1, 2'b10, 1};

    rst = 1'b0;
    {DPin, DMin} = LJ;
    dec_bit = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs",
        32'({rx_active, rx_valid, rx_done, rx_error, rx_err_code, rx_data, rx_byte_cnt}), 32'd0);
    rst = 1'b1;
    idle(3);

    for (int v = 0; v < 7; v++) begin
      pkt_q.delete();
      for (int b = 0; b < tbl[v].nbytes; b++) pkt_q.push_back(tbl[v].bytes[8*b +: 8]);
      run_packet(3, tbl[v].nz, tbl[v].extra, tbl[v].xbits, tbl[v].exp_err,
                 tbl[v].exp_code, tbl[v].exp_cnt, $sformatf("vec%0d", v));
    end

    // Stuffing violation: the run includes the SYNC's 1, so the 6th data 1 is illegal.
    bd = n_done; be = n_err;
    idle(3);
    sync(7);
    for (int i = 0; i < 5; i++) sym(LJ, 1'b1);
    chk("stuff active before", 32'(rx_active), 32'd1);
    sym(LJ, 1'b1);
    chk("stuff error pulse", 32'(rx_error), 32'd1);
    chk("stuff code", 32'(rx_err_code), 32'd1);
    chk("stuff active after", 32'(rx_active), 32'd0);
    sym(LJ, 1'b1);
    chk("stuff error one cycle", 32'(rx_error), 32'd0);
    recover();
    chk("stuff code held", 32'(rx_err_code), 32'd1);
    chk("stuff no done", 32'(n_done - bd), 32'd0);
    chk("stuff error count", 32'(n_err - be), 32'd1);
    pkt_q.delete();
    pkt_q.push_back(8'hA5);
    pkt_q.push_back(8'h3C);
    run_packet(0, 7, 0, 8'h00, 1'b0, 2'b00, 2, "after stuff");

    // Single SE0 then J is a framing error.
    bd = n_done;
    idle(3);
    sync(7);
    sym(LSE0, 1'b0);
    chk("short eop active", 32'(rx_active), 32'd1);
    sym(LJ, 1'b1);
    chk("short eop error", 32'(rx_error), 32'd1);
    chk("short eop code", 32'(rx_err_code), 32'd2);
    chk("short eop active after", 32'(rx_active), 32'd0);
    chk("short eop no done", 32'(n_done - bd), 32'd0);
    recover();

    // SE1 inside a packet.
    idle(3);
    sync(7);
    send_byte(8'h5A);
    sym(LSE1, 1'b0);
    chk("se1 error", 32'(rx_error), 32'd1);
    chk("se1 code", 32'(rx_err_code), 32'd3);
    chk("se1 active", 32'(rx_active), 32'd0);
    recover();

    // Four SE0 bit-times is too long an EOP.
    idle(3);
    sync(7);
    send_byte(8'h5A);
    for (int i = 0; i < 3; i++) sym(LSE0, 1'b0);
    chk("long eop still active", 32'(rx_active), 32'd1);
    sym(LSE0, 1'b0);
    chk("long eop error", 32'(rx_error), 32'd1);
    chk("long eop code", 32'(rx_err_code), 32'd2);
    recover();

    // Too few leading zeros never starts a packet.
    ba = n_act;
    idle(3);
    for (int i = 0; i < 4; i++) sym(LK, 1'b0);
    sym(LK, 1'b1);
    idle(8);
    for (int i = 0; i < 5; i++) sym(LK, 1'b0);
    sym(LK, 1'b1);
    idle(8);
    chk("short sync no active", 32'(n_act - ba), 32'd0);

    // Asynchronous reset in the middle of a byte.
    bd = n_done; be = n_err;
    idle(3);
    sync(7);
    for (int i = 0; i < 4; i++) send_bit(1'(i));
    #2 rst = 1'b0;
    #1;
    chk("mid reset outputs",
        32'({rx_active, rx_valid, rx_done, rx_error, rx_err_code, rx_data, rx_byte_cnt}), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    chk("mid reset no done", 32'(n_done - bd), 32'd0);
    chk("mid reset no error", 32'(n_err - be), 32'd0);
    pkt_q.delete();
    pkt_q.push_back(8'hC3);
    run_packet(3, 7, 0, 8'h00, 1'b0, 2'b00, 1, "after reset");

    // Randomized packets; expected outcome from the packet-level rules.
    for (int t = 0; t < 25; t++) begin
      n     = $urandom_range(0, 6);
      extra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      nz    = $urandom_range(6, 9);
      xb    = 8'($urandom);
      pkt_q.delete();
      for (int i = 0; i < n; i++) pkt_q.push_back(8'($urandom));
      run_packet(3, nz, extra, xb, extra != 0, (extra != 0) ? 2'b10 : 2'b00, n,
                 $sformatf("rand%0d", t));
    end

    // Overflow: MAX_BYTES deliver, the next one aborts without rx_valid.
    bv = got_q.size(); be = n_err; bd = n_done;
    pkt_q.delete();
    for (int i = 0; i <= MAXB; i++) pkt_q.push_back(8'($urandom));
    idle(3);
    sync(7);
    foreach (pkt_q[i]) send_byte(pkt_q[i]);
    idle(1);
    chk("ovf valid count", 32'(got_q.size() - bv), 32'(MAXB));
    n = 0;
    for (int i = 0; i < MAXB; i++)
      if (bv + i >= got_q.size() || got_q[bv + i] !== pkt_q[i]) n++;
    chk("ovf bytes", 32'(n), 32'd0);
    chk("ovf error count", 32'(n_err - be), 32'd1);
    chk("ovf code", 32'(rx_err_code), 32'd3);
    chk("ovf active", 32'(rx_active), 32'd0);
    chk("ovf data held", 32'(rx_data), 32'(pkt_q[MAXB-1]));
    chk("ovf no done", 32'(n_done - bd), 32'd0);
    recover();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
